// File: rtl/ed25519_in_serializer.sv
// ed25519_in_serializer
// Takes one scalar-multiplication job (M, X, Y) over a parallel valid/ready port.
// Optionally reduces X and Y modulo q = 2^255 - 19 with two conditional-subtract
// passes. Then streams the job as twelve 64-bit beats, M first, then X, then Y,
// most-significant word of each first.
module ed25519_in_serializer #(
   parameter bit REDUCE = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_job_valid,
   output logic         o_job_ready,
   input  logic [255:0] i_scalar_m,
   input  logic [255:0] i_point_x,
   input  logic [255:0] i_point_y,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [63:0]  o_out_data,
   output logic         o_busy
);

   // Field prime q = 2^255 - 19.
   localparam logic [255:0] Q = {4'h7, {61{4'hf}}, 8'hed};

   localparam logic [3:0] LAST_BEAT = 4'd11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RED1 = 2'd1,
      RED2 = 2'd2,
      SEND = 2'd3
   } state_t;

   state_t       state, state_nxt;
   logic [3:0]   beat_cnt;
   logic [255:0] reg_m, reg_x, reg_y;

   logic         accept;
   logic         beat_done;
   logic         last_done;
   logic [255:0] sect_sel;

   // One reduction pass: subtract q once if the value is at least q.
   // Two passes cover all 256-bit inputs because 2^256 - 1 = 2q + 37.
   function automatic logic [255:0] cond_sub_q(input logic [255:0] v);
      if (v >= Q) begin
         return v - Q;
      end
      return v;
   endfunction

   assign accept    = (state == IDLE) && i_job_valid;
   assign beat_done = (state == SEND) && i_out_ready;
   assign last_done = beat_done && (beat_cnt == LAST_BEAT);

   // State register; reset wins over every in-flight job or beat.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_job_valid) begin
               state_nxt = REDUCE ? RED1 : SEND;
            end
         end
         RED1:    state_nxt = RED2;
         RED2:    state_nxt = SEND;
         SEND: begin
            if (last_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Beat counter: cleared on accept, stepped on each accepted beat.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         beat_cnt <= 4'd0;
      end else if (accept) begin
         beat_cnt <= 4'd0;
      end else if (beat_done && !last_done) begin
         beat_cnt <= beat_cnt + 4'd1;
      end
   end

   // Job registers: latch on accept, reduce X and Y in place during RED1/RED2.
   // M is never reduced.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         reg_m <= '0;
         reg_x <= '0;
         reg_y <= '0;
      end else if (accept) begin
         reg_m <= i_scalar_m;
         reg_x <= i_point_x;
         reg_y <= i_point_y;
      end else if ((state == RED1) || (state == RED2)) begin
         reg_x <= cond_sub_q(reg_x);
         reg_y <= cond_sub_q(reg_y);
      end
   end

   // Beat mux: section = beat/4 picks M, X or Y; word = beat%4 picks the 64-bit
   // slice, most-significant first.
   always_comb begin
      sect_sel   = reg_m;
      o_out_data = 64'd0;
      case (beat_cnt[3:2])
         2'd0:    sect_sel = reg_m;
         2'd1:    sect_sel = reg_x;
         default: sect_sel = reg_y;
      endcase
      if (state == SEND) begin
         case (beat_cnt[1:0])
            2'd0:    o_out_data = sect_sel[255:192];
            2'd1:    o_out_data = sect_sel[191:128];
            2'd2:    o_out_data = sect_sel[127:64];
            default: o_out_data = sect_sel[63:0];
         endcase
      end
   end

   assign o_job_ready = (state == IDLE);
   assign o_out_valid = (state == SEND);
   assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_ed25519_in_serializer.sv
// Directed bench for ed25519_in_serializer: one instance with reduction, one without.
module tb_ed25519_in_serializer;

   localparam logic [255:0] Q = {4'h7, {61{4'hf}}, 8'hed};
   localparam logic [255:0] ORD_M = {64'd1, 64'd2, 64'd3, 64'd4};
   localparam logic [255:0] ORD_X = {64'd5, 64'd6, 64'd7, 64'd8};
   localparam logic [255:0] ORD_Y = {64'd9, 64'd10, 64'd11, 64'd12};

   logic         clk = 1'b0;
   logic         rst;
   // instance with reduction
   logic         job_valid, job_ready, out_valid, out_ready, busy;
   logic [255:0] in_m, in_x, in_y;
   logic [63:0]  out_data;
   // instance without reduction
   logic         z_job_valid, z_job_ready, z_out_valid, z_out_ready, z_busy;
   logic [255:0] z_m, z_x, z_y;
   logic [63:0]  z_out_data;

   int           total = 0;
   int           bad = 0;
   logic [63:0]  exp_b [12];
   logic         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   ed25519_in_serializer #(.REDUCE(1'b1)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_job_valid(job_valid), .o_job_ready(job_ready),
      .i_scalar_m(in_m), .i_point_x(in_x), .i_point_y(in_y),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_data(out_data), .o_busy(busy)
   );

   ed25519_in_serializer #(.REDUCE(1'b0)) dut_nr (
      .i_clk(clk), .i_rst(rst),
      .i_job_valid(z_job_valid), .o_job_ready(z_job_ready),
      .i_scalar_m(z_m), .i_point_x(z_x), .i_point_y(z_y),
      .o_out_valid(z_out_valid), .i_out_ready(z_out_ready),
      .o_out_data(z_out_data), .o_busy(z_busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a job, then check the two reduce cycles. Leaves the DUT in SEND.
   task automatic start_job(input logic [255:0] m, input logic [255:0] x,
                            input logic [255:0] y, input string tag);
      chk({tag, "_ready_idle"}, {63'd0, job_ready}, 64'd1);
      in_m = m; in_x = x; in_y = y;
      job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
      chk({tag, "_red1_valid"}, {63'd0, out_valid}, 64'd0);
      chk({tag, "_red1_busy"}, {63'd0, busy}, 64'd1);
      tick();
      chk({tag, "_red2_valid"}, {63'd0, out_valid}, 64'd0);
      tick();
   endtask

   // Consume n beats, checking data every cycle (held while stalled).
   task automatic run_beats(input int n, input bit bp, input string tag);
      int k = 0;
      int cyc = 0;
      while (k < n && cyc < 200) begin
         out_ready = bp ? pat[cyc % 6] : 1'b1;
         chk($sformatf("%s_valid%0d", tag, k), {63'd0, out_valid}, 64'd1);
         chk($sformatf("%s_beat%0d", tag, k), out_data, exp_b[k]);
         if (out_ready) k++;
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      chk({tag, "_handshakes"}, 64'(k), 64'(n));
   endtask

   task automatic check_idle_after(input string tag);
      chk({tag, "_end_ready"}, {63'd0, job_ready}, 64'd1);
      chk({tag, "_end_valid"}, {63'd0, out_valid}, 64'd0);
   endtask

   task automatic exp_ordering();
      for (int i = 0; i < 12; i++) exp_b[i] = 64'(i + 1);
   endtask

   initial begin
      rst = 1'b0;
      job_valid = 1'b0; out_ready = 1'b0;
      in_m = '0; in_x = '0; in_y = '0;
      z_job_valid = 1'b0; z_out_ready = 1'b0;
      z_m = '0; z_x = '0; z_y = '0;
      tick();
      tick();
      chk("rst_ready", {63'd0, job_ready}, 64'd1);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      rst = 1'b1;
      tick();

      // Ordering, no backpressure
      exp_ordering();
      start_job(ORD_M, ORD_X, ORD_Y, "ord");
      run_beats(12, 1'b0, "ord");
      check_idle_after("ord");

      // Reduction of X = q+5, Y = 2^256-1; M all ones stays unreduced
      for (int i = 0; i < 4; i++) exp_b[i] = 64'hffff_ffff_ffff_ffff;
      exp_b[4] = 64'd0; exp_b[5] = 64'd0; exp_b[6] = 64'd0; exp_b[7] = 64'h5;
      exp_b[8] = 64'd0; exp_b[9] = 64'd0; exp_b[10] = 64'd0; exp_b[11] = 64'h25;
      start_job({256{1'b1}}, Q + 256'd5, {256{1'b1}}, "red");
      run_beats(12, 1'b0, "red");
      check_idle_after("red");

      // X = q-1 must pass unchanged
      for (int i = 0; i < 4; i++) exp_b[i] = 64'(i + 1);
      exp_b[4] = 64'h7fff_ffff_ffff_ffff; exp_b[5] = 64'hffff_ffff_ffff_ffff;
      exp_b[6] = 64'hffff_ffff_ffff_ffff; exp_b[7] = 64'hffff_ffff_ffff_ffec;
      for (int i = 8; i < 12; i++) exp_b[i] = 64'd0;
      start_job(ORD_M, Q - 256'd1, 256'd0, "qm1");
      run_beats(12, 1'b0, "qm1");
      check_idle_after("qm1");

      // Backpressure 1,0,0,1,0,1...
      exp_ordering();
      start_job(ORD_M, ORD_X, ORD_Y, "bp");
      run_beats(12, 1'b1, "bp");
      check_idle_after("bp");

      // Busy rejection: second job held during job 1's SEND
      exp_ordering();
      start_job(ORD_M, ORD_X, ORD_Y, "busy1");
      in_m = {256{1'b1}}; in_x = Q + 256'd5; in_y = {256{1'b1}};
      job_valid = 1'b1;
      chk("busy_ready_send", {63'd0, job_ready}, 64'd0);
      run_beats(12, 1'b0, "busy1");
      chk("busy_ready_after", {63'd0, job_ready}, 64'd1);
      tick();
      job_valid = 1'b0;
      chk("busy2_accepted", {63'd0, busy}, 64'd1);
      chk("busy2_red1_valid", {63'd0, out_valid}, 64'd0);
      tick();
      tick();
      for (int i = 0; i < 4; i++) exp_b[i] = 64'hffff_ffff_ffff_ffff;
      exp_b[4] = 64'd0; exp_b[5] = 64'd0; exp_b[6] = 64'd0; exp_b[7] = 64'h5;
      exp_b[8] = 64'd0; exp_b[9] = 64'd0; exp_b[10] = 64'd0; exp_b[11] = 64'h25;
      run_beats(12, 1'b0, "busy2");
      check_idle_after("busy2");

      // Reset after beat 5 is accepted, then a fresh job
      exp_ordering();
      start_job(ORD_M, ORD_X, ORD_Y, "mid");
      run_beats(6, 1'b0, "mid");
      rst = 1'b0;
      tick();
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      rst = 1'b1;
      tick();
      chk("mid_rel_ready", {63'd0, job_ready}, 64'd1);
      start_job(ORD_M, ORD_X, ORD_Y, "fresh");
      run_beats(12, 1'b0, "fresh");
      check_idle_after("fresh");

      // No-reduce instance: X = 2^256-1, beat 0 the cycle after accept
      chk("nr_ready", {63'd0, z_job_ready}, 64'd1);
      z_m = ORD_M; z_x = {256{1'b1}}; z_y = ORD_Y;
      z_job_valid = 1'b1;
      z_out_ready = 1'b1;
      tick();
      z_job_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("nr_valid%0d", k), {63'd0, z_out_valid}, 64'd1);
         chk($sformatf("nr_beat%0d", k), z_out_data,
             (k >= 4 && k < 8) ? 64'hffff_ffff_ffff_ffff : 64'(k + 1));
         tick();
      end
      chk("nr_end_ready", {63'd0, z_job_ready}, 64'd1);
      chk("nr_end_valid", {63'd0, z_out_valid}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
